// File: rtl/obstacle_sprite_if.sv
// Scan, sprite-ROM and pixel-output signals between the VGA scan side and an obstacle renderer.
interface obstacle_sprite_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              step;
    logic              rdn;
    logic [9:0]        col_addr;
    logic [8:0]        row_addr;
    logic              fg_in;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [11:0]       dout;
    logic              busy;
    logic              finish;
    logic              hit;

    modport master (
        output start, step, rdn, col_addr, row_addr, fg_in, rom_data,
        input  rom_addr, dout, busy, finish, hit
    );

    modport slave (
        input  start, step, rdn, col_addr, row_addr, fg_in, rom_data,
        output rom_addr, dout, busy, finish, hit
    );
endinterface

// File: rtl/obstacle_sprite.sv
// Scrolling obstacle sprite: position/animation state, sync-ROM addressing,
// 2-cycle pixel pipeline with transparent keying and sticky collision flag.
module obstacle_sprite #(
    parameter int          WIDTH     = 24,
    parameter int          HEIGHT    = 49,
    parameter int          COLNUM    = 640,
    parameter int          BASE_ROW  = 300,
    parameter int          SPEED     = 1,
    parameter int          FRAMES    = 1,
    parameter int          FRAME_DIV = 8,
    parameter int          ADDR_W    = 12,
    parameter logic [11:0] TRANSP    = 12'h000,
    parameter logic [11:0] BG        = 12'hfff
) (
    input logic              clk,
    input logic              rstn,
    obstacle_sprite_if.slave bus
);
    localparam logic [11:0] LIMIT   = 12'(COLNUM + WIDTH);
    localparam logic [11:0] COL_LO  = 12'(COLNUM);
    localparam logic [11:0] ROW_TOP = 12'(BASE_ROW - HEIGHT);
    localparam logic [11:0] ROW_BOT = 12'(BASE_ROW);
    localparam logic [1:0]  FR_LAST = 2'(FRAMES - 1);
    localparam logic [7:0]  DV_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    logic [11:0] r_count;
    logic [1:0]  r_frame;
    logic [7:0]  r_div;
    logic        r_busy;
    logic        r_finish;
    logic        r_hit;
    logic [11:0] r_dout;
    logic        r_inwin;
    logic        r_fg;
    logic        r_rd;

    logic [11:0]       w_colsum;
    logic [11:0]       w_row;
    logic [11:0]       w_step_sum;
    logic              w_inwin;
    logic              w_opaque;
    logic [ADDR_W-1:0] w_frame_base;
    logic [ADDR_W-1:0] w_row_off;
    logic [ADDR_W-1:0] w_col_off;

    always_comb begin
        w_colsum   = r_count + {2'b00, bus.col_addr};
        w_row      = {3'b000, bus.row_addr};
        w_step_sum = r_count + 12'(SPEED);
        w_inwin    = r_busy && !bus.rdn
                     && (w_colsum >= COL_LO) && (w_colsum < LIMIT)
                     && (w_row > ROW_TOP) && (w_row <= ROW_BOT);
        w_opaque   = r_inwin && r_rd && (bus.rom_data != TRANSP);
        w_frame_base = ADDR_W'(r_frame) * ADDR_W'(WIDTH * HEIGHT);
        w_row_off    = ADDR_W'(w_row - (ROW_TOP + 12'd1)) * ADDR_W'(WIDTH);
        w_col_off    = ADDR_W'(w_colsum - COL_LO);
    end

    assign bus.rom_addr = w_frame_base + w_row_off + w_col_off;
    assign bus.dout     = r_dout;
    assign bus.busy     = r_busy;
    assign bus.finish   = r_finish;
    assign bus.hit      = r_hit;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_count  <= LIMIT;
            r_frame  <= '0;
            r_div    <= '0;
            r_busy   <= 1'b0;
            r_finish <= 1'b1;
            r_hit    <= 1'b0;
            r_dout   <= BG;
            r_inwin  <= 1'b0;
            r_fg     <= 1'b0;
            r_rd     <= 1'b0;
        end else begin
            // The in-flight pixel uses the count sampled with its address, so a
            // step at the same edge only affects later addresses.
            r_inwin <= w_inwin;
            r_fg    <= bus.fg_in;
            r_rd    <= ~bus.rdn;
            r_dout  <= w_opaque ? bus.rom_data : BG;

            if (bus.start) begin
                r_state  <= RUN;
                r_busy   <= 1'b1;
                r_finish <= 1'b0;
                r_count  <= '0;
                r_frame  <= '0;
                r_div    <= '0;
                r_hit    <= 1'b0;
            end else begin
                if (w_opaque && r_fg)
                    r_hit <= 1'b1;
                if (r_state == RUN && bus.step) begin
                    if (w_step_sum >= LIMIT) begin
                        r_count  <= LIMIT;
                        r_state  <= IDLE;
                        r_busy   <= 1'b0;
                        r_finish <= 1'b1;
                    end else begin
                        r_count <= w_step_sum;
                    end
                    if (r_div == DV_LAST) begin
                        r_div   <= '0;
                        r_frame <= (r_frame == FR_LAST) ? 2'd0 : r_frame + 2'd1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_obstacle_sprite.sv
// Bench for obstacle_sprite: default instance checked through a dout scoreboard,
// a fast two-frame instance checked on its ROM address.
module tb_obstacle_sprite;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    obstacle_sprite_if #(.ADDR_W(12)) bus0 ();
    obstacle_sprite_if #(.ADDR_W(12)) bus1 ();

    obstacle_sprite u0 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus0)
    );

    obstacle_sprite #(
        .SPEED    (5),
        .FRAMES   (2),
        .FRAME_DIV(8)
    ) u1 (
        .clk (clk),
        .rstn(rstn),
        .bus (bus1)
    );

    logic [11:0] rom_val0 = 12'h000;
    always @(posedge clk) bus0.rom_data <= rom_val0;
    always @(posedge clk) bus1.rom_data <= 12'h000;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        int unsigned due;
        logic [11:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    always @(posedge clk) begin
        sb_t e;
        #1;
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check(e.name, {20'd0, bus0.dout}, {20'd0, e.exp});
        end
    end

    typedef struct {
        logic        rdn;
        logic [9:0]  col;
        logic [8:0]  row;
        logic        fg;
        logic [11:0] rom;
        logic [11:0] exp;
        logic        chk_a;
        logic [11:0] exp_a;
        string       name;
    } vec_t;

    task automatic drive_px(input logic rdn, input logic [9:0] col, input logic [8:0] row,
                            input logic fg, input logic [11:0] rom, input logic [11:0] exp,
                            input logic chk_a, input logic [11:0] exp_a, input string name);
        @(negedge clk);
        bus0.rdn      = rdn;
        bus0.col_addr = col;
        bus0.row_addr = row;
        bus0.fg_in    = fg;
        rom_val0      = rom;
        sb_q.push_back('{cyc + 2, exp, name});
        if (chk_a) begin
            #1;
            check({name, "_addr"}, {20'd0, bus0.rom_addr}, {20'd0, exp_a});
        end
    endtask

    task automatic idle_px();
        @(negedge clk);
        bus0.rdn   = 1'b1;
        bus0.fg_in = 1'b0;
        rom_val0   = 12'h000;
    endtask

    task automatic steps(input int sel, input int n);
        @(negedge clk);
        if (sel == 0) bus0.step = 1'b1; else bus1.step = 1'b1;
        repeat (n) @(negedge clk);
        bus0.step = 1'b0;
        bus1.step = 1'b0;
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic addr1(input logic [9:0] col, input logic [8:0] row,
                         input logic [11:0] exp, input string name);
        bus1.col_addr = col;
        bus1.row_addr = row;
        #1;
        check(name, {20'd0, bus1.rom_addr}, {20'd0, exp});
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{1'b0, 10'd0,  9'd252, 1'b0, 12'h0a0, 12'h0a0, 1'b1, 12'd0,    "v_origin"};
        vt[1] = '{1'b0, 10'd24, 9'd252, 1'b0, 12'h0a0, 12'hfff, 1'b0, 12'd0,    "v_col_past"};
        vt[2] = '{1'b0, 10'd23, 9'd300, 1'b0, 12'h123, 12'h123, 1'b1, 12'd1175, "v_corner"};
        vt[3] = '{1'b0, 10'd5,  9'd251, 1'b0, 12'h0a0, 12'hfff, 1'b0, 12'd0,    "v_row_above"};
        vt[4] = '{1'b0, 10'd5,  9'd301, 1'b0, 12'h0a0, 12'hfff, 1'b0, 12'd0,    "v_row_below"};
        vt[5] = '{1'b1, 10'd5,  9'd260, 1'b1, 12'h0a0, 12'hfff, 1'b1, 12'd197,  "v_rdn_high"};
        vt[6] = '{1'b0, 10'd5,  9'd260, 1'b1, 12'h000, 12'hfff, 1'b1, 12'd197,  "v_transp"};
        vt[7] = '{1'b0, 10'd10, 9'd270, 1'b0, 12'hf00, 12'hf00, 1'b1, 12'd442,  "v_mid"};

        bus0.start = 1'b0; bus0.step = 1'b0; bus0.rdn = 1'b1;
        bus0.col_addr = '0; bus0.row_addr = '0; bus0.fg_in = 1'b0;
        bus1.start = 1'b0; bus1.step = 1'b0; bus1.rdn = 1'b1;
        bus1.col_addr = '0; bus1.row_addr = '0; bus1.fg_in = 1'b0;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        check("rst_dout",   {20'd0, bus0.dout}, 32'hfff);
        check("rst_busy",   {31'd0, bus0.busy}, 32'd0);
        check("rst_finish", {31'd0, bus0.finish}, 32'd1);
        check("rst_hit",    {31'd0, bus0.hit}, 32'd0);

        // Idle scan over a coarse grid of the frame: always background, no hit.
        for (int r = 0; r < 480; r += 30)
            for (int c = 0; c < 1024; c += 53)
                drive_px(1'b0, 10'(c), 9'(r), 1'b1, 12'h0a0, 12'hfff, 1'b0, 12'd0, "idle_scan");
        idle_px(); idle_px();
        check("idle_hit",    {31'd0, bus0.hit}, 32'd0);
        check("idle_finish", {31'd0, bus0.finish}, 32'd1);

        pulse_start(0);
        check("start_busy",   {31'd0, bus0.busy}, 32'd1);
        check("start_finish", {31'd0, bus0.finish}, 32'd0);
        steps(0, 640);
        check("run_busy", {31'd0, bus0.busy}, 32'd1);

        for (int i = 0; i < 8; i++)
            drive_px(vt[i].rdn, vt[i].col, vt[i].row, vt[i].fg, vt[i].rom,
                     vt[i].exp, vt[i].chk_a, vt[i].exp_a, vt[i].name);
        idle_px(); idle_px();
        check("no_hit_transp_rdn", {31'd0, bus0.hit}, 32'd0);

        drive_px(1'b0, 10'd2, 9'd260, 1'b1, 12'h0a0, 12'h0a0, 1'b1, 12'd194, "hit_px");
        idle_px(); idle_px();
        check("hit_set", {31'd0, bus0.hit}, 32'd1);
        repeat (5) idle_px();
        check("hit_hold", {31'd0, bus0.hit}, 32'd1);

        steps(0, 23);
        check("pre_end_busy", {31'd0, bus0.busy}, 32'd1);
        steps(0, 1);
        check("end_finish",   {31'd0, bus0.finish}, 32'd1);
        check("end_busy",     {31'd0, bus0.busy}, 32'd0);
        check("end_hit_hold", {31'd0, bus0.hit}, 32'd1);
        drive_px(1'b0, 10'd0, 9'd252, 1'b0, 12'h0a0, 12'hfff, 1'b0, 12'd0, "after_end");
        idle_px();

        pulse_start(0);
        check("start_clr_hit", {31'd0, bus0.hit}, 32'd0);
        steps(0, 10);
        @(negedge clk);
        bus0.start = 1'b1; bus0.step = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0; bus0.step = 1'b0;
        drive_px(1'b0, 10'd640, 9'd252, 1'b0, 12'h0a0, 12'h0a0, 1'b1, 12'd0, "start_step");
        idle_px();

        // Saturating step on the SPEED=5, two-frame instance.
        pulse_start(1);
        steps(1, 132);
        check("sat_busy", {31'd0, bus1.busy}, 32'd1);
        addr1(10'd3, 9'd252, 12'd23, "sat_addr0");
        addr1(10'd3, 9'd253, 12'd47, "sat_addr1");
        steps(1, 1);
        check("sat_finish", {31'd0, bus1.finish}, 32'd1);
        check("sat_busy_lo", {31'd0, bus1.busy}, 32'd0);

        pulse_start(1);
        addr1(10'd640, 9'd252, 12'd0, "frame0_addr");
        steps(1, 8);
        addr1(10'd600, 9'd252, 12'd1176, "frame1_addr");
        addr1(10'd601, 9'd253, 12'd1201, "frame1_addr_b");
        steps(1, 8);
        addr1(10'd560, 9'd252, 12'd0, "frame_wrap_addr");

        // Mid-operation reset discards an opaque, colliding pixel in flight.
        pulse_start(0);
        drive_px(1'b0, 10'd640, 9'd260, 1'b1, 12'h0a0, 12'hfff, 1'b0, 12'd0, "reset_flight");
        @(negedge clk);
        bus0.rdn = 1'b1; bus0.fg_in = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("mid_rst_hit",    {31'd0, bus0.hit}, 32'd0);
        check("mid_rst_busy",   {31'd0, bus0.busy}, 32'd0);
        check("mid_rst_finish", {31'd0, bus0.finish}, 32'd1);
        check("mid_rst_dout",   {20'd0, bus0.dout}, 32'hfff);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
